// File: rtl/mux_uart_if.sv
`timescale 1ns/1ps
// mux_uart_if: CPU6 bus view of the MUX serial channel.
//   address   19  bus address (master -> slave)
//   write_en   1  write strobe, sampled on clock posedge
//   read_en    1  one-cycle read strobe; only data-register reads have a side effect
//   data_in    8  write data
//   data_out   8  read data, combinational from address, 0 when not selected
//   sel        1  combinational address match (status or data register)
//   tx_state_dbg / rx_state_dbg  2  current transmitter / receiver FSM state
// Handshake: there is no valid/ready pair. A strobe high at a posedge is a
// complete transfer on that edge; the slave never stalls the master.
interface mux_uart_if;
    logic [18:0] address;
    logic        write_en;
    logic        read_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        sel;
    logic [1:0]  tx_state_dbg;
    logic [1:0]  rx_state_dbg;

    modport master (
        output address, write_en, read_en, data_in,
        input  data_out, sel, tx_state_dbg, rx_state_dbg
    );

    modport slave (
        input  address, write_en, read_en, data_in,
        output data_out, sel, tx_state_dbg, rx_state_dbg
    );
endinterface

// File: rtl/mux_uart.sv
`timescale 1ns/1ps
// mux_uart: memory-mapped 8N1 serial channel. TX side has a small FIFO in
// front of a shift register; RX side holds a single received byte.
//   clock  in   system clock, all state changes on posedge
//   reset  in   synchronous, active-high
//   bus    slave modport of mux_uart_if (address/strobes/data, sel, FSM debug)
//   txd    out  serial transmit, idle high
//   rxd    in   serial receive, asynchronous, idle high
// Registers: BASE_ADDR = status (write clears sticky bits 3..5),
//            BASE_ADDR+1 = data (write pushes TX FIFO, read returns rx_buf).
module mux_uart #(
    parameter logic [18:0] BASE_ADDR    = 19'h3f200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic         clock,
    input  logic         reset,
    mux_uart_if.slave    bus,
    output logic         txd,
    input  logic         rxd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [18:0]   DATA_ADDR = BASE_ADDR + 19'd1;
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // bus decode
    logic stat_wr, data_wr, data_rd;
    assign bus.sel  = (bus.address == BASE_ADDR) || (bus.address == DATA_ADDR);
    assign stat_wr  = bus.write_en && (bus.address == BASE_ADDR);
    assign data_wr  = bus.write_en && (bus.address == DATA_ADDR);
    assign data_rd  = bus.read_en  && (bus.address == DATA_ADDR);

    // TX FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty, push, pop;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_bit_end;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // fullness is judged on the count before the edge, so a push into a full
    // FIFO is dropped even if a pop frees a slot on the same edge
    assign push       = data_wr && !fifo_full;
    assign tx_bit_end = (tx_cnt == BIT_END);
    // a new frame starts straight from IDLE, or from the end of a stop bit
    // so back-to-back frames have no gap
    assign pop = !fifo_empty &&
                 ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // TX FSM; txd is registered
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            txd      <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (pop) begin
                        tx_state <= TX_START;
                        txd      <= 1'b0;
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_cnt   <= '0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        txd      <= tx_shift[0];
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            txd      <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (pop) begin
                            tx_state <= TX_START;
                            txd      <= 1'b0;
                            tx_shift <= fifo_mem[rd_ptr];
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX: two-flop synchronizer plus one more flop for falling-edge detection
    logic rx_meta, rx_s, rx_prev, rx_fall;
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end
    assign rx_fall = rx_prev && !rx_s;

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_stop_smp, rx_good, rx_frm;

    assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == BIT_END);
    assign rx_good     = rx_stop_smp && rx_s;
    assign rx_frm      = rx_stop_smp && !rx_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // half a bit in: a high line means the edge was a glitch
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // leave at the stop mid-bit so the next start edge is seen at once
                    if (rx_stop_smp) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // receive buffer and sticky flags
    logic [7:0] rx_buf;
    logic       rx_full, rx_ovr, tx_ovf, frm_err, rx_load;

    // a data read on the same edge as a completed byte frees the buffer for it
    assign rx_load = rx_good && (!rx_full || data_rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_buf  <= '0;
            rx_full <= 1'b0;
            rx_ovr  <= 1'b0;
            tx_ovf  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_buf  <= rx_shift;
                rx_full <= 1'b1;
            end else if (data_rd) begin
                rx_full <= 1'b0;
            end
            if (rx_good && !rx_load)       rx_ovr  <= 1'b1;
            else if (stat_wr)              rx_ovr  <= 1'b0;
            if (data_wr && fifo_full)      tx_ovf  <= 1'b1;
            else if (stat_wr)              tx_ovf  <= 1'b0;
            if (rx_frm)                    frm_err <= 1'b1;
            else if (stat_wr)              frm_err <= 1'b0;
        end
    end

    logic [7:0] status;
    assign status = {2'b00, frm_err, tx_ovf, rx_ovr,
                     fifo_empty && (tx_state == TX_IDLE), !fifo_full, rx_full};

    always_comb begin
        bus.data_out = 8'h00;
        if (bus.address == BASE_ADDR)      bus.data_out = status;
        else if (bus.address == DATA_ADDR) bus.data_out = rx_buf;
    end

    assign bus.tx_state_dbg = tx_state;
    assign bus.rx_state_dbg = rx_state;
endmodule
